// File: rtl/serial_code_lock_pkg.sv
// Shared definitions for the serial code lock.
//   COLLECT/CHECK/OPEN/LOCKOUT : FSM state encodings
//   TIMER_W                    : width of the open/lockout down-counter
//   CNT_W                      : width of the bit and fail counters
package serial_code_lock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t COLLECT = 2'd0;
    localparam state_t CHECK   = 2'd1;
    localparam state_t OPEN    = 2'd2;
    localparam state_t LOCKOUT = 2'd3;

    localparam int TIMER_W = 16;
    localparam int CNT_W   = 3;

endpackage

// File: rtl/serial_code_lock_if.sv
// Bus between the code-entry source and the lock controller.
//   din, din_valid, clear : serial entry from the source (master)
//   unlock, alarm         : lock status from the controller (slave)
//   bit_cnt, fails        : progress / fail count from the controller
interface serial_code_lock_if;
    import serial_code_lock_pkg::*;

    logic             din;
    logic             din_valid;
    logic             clear;
    logic             unlock;
    logic             alarm;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] fails;

    modport master (
        output din, din_valid, clear,
        input  unlock, alarm, bit_cnt, fails
    );

    modport slave (
        input  din, din_valid, clear,
        output unlock, alarm, bit_cnt, fails
    );

endinterface

// File: rtl/serial_code_lock_sync_edge_det.sv
// Input conditioning for the serial code lock.
// With SERIAL_CODE_LOCK_SYNC_EN defined, din, din_valid and clear each pass
// through a 2-flop synchronizer (reset to 0); otherwise they are used as-is.
// A rising-edge detector on the (optionally synchronized) din_valid yields stb.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   din, din_valid      : raw serial bit and strobe
//   clear               : raw abort request
//   din_s, clear_s      : conditioned din / clear
//   stb                 : one-cycle pulse on each din_valid rising edge
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic din_valid,
    input  logic clear,
    output logic din_s,
    output logic clear_s,
    output logic stb
);

    logic din_valid_s;
    logic din_valid_q;

`ifdef SERIAL_CODE_LOCK_SYNC_EN
    logic [2:0] sync_1;
    logic [2:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {din_valid, clear, din};
            sync_2 <= sync_1;
        end
    end

    assign {din_valid_s, clear_s, din_s} = sync_2;
`else
    assign din_valid_s = din_valid;
    assign clear_s     = clear;
    assign din_s       = din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_valid_q <= 1'b0;
        else        din_valid_q <= din_valid_s;
    end

    // A strobe held high counts only once.
    assign stb = din_valid_s & ~din_valid_q;

endmodule

// File: rtl/serial_code_lock.sv
// Serial combination-code lock controller.
// Strobed serial bits are assembled MSB-first into a byte and compared with
// CODE. A match opens the lock for UNLOCK_CYCLES; MAX_TRIES consecutive
// mismatches raise the alarm for LOCKOUT_CYCLES.
// Optional build macro: SERIAL_CODE_LOCK_SYNC_EN (2-flop input synchronizers,
// adds 2 cycles to every input-to-response latency).
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_code_lock_if.slave (din, din_valid, clear in;
//            unlock, alarm, bit_cnt, fails out, all registered)
//
// state   | meaning
// --------+------------------------------------------------------
// COLLECT | shifting in bits on each strobe; clear aborts entry
// CHECK   | one cycle: compare byte, update fail count
// OPEN    | unlock high until the timer reaches 0
// LOCKOUT | alarm high until the timer reaches 0, then fails=0
module serial_code_lock
    import serial_code_lock_pkg::*;
#(
    parameter logic [7:0] CODE           = 8'hBD,
    parameter int         MAX_TRIES      = 3,
    parameter int         UNLOCK_CYCLES  = 255,
    parameter int         LOCKOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_code_lock_if.slave  bus
);

    localparam logic [CNT_W-1:0]   MAX_T    = CNT_W'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] UNLOCK_T = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_T   = TIMER_W'(LOCKOUT_CYCLES - 1);

    logic din_s;
    logic clear_s;
    logic stb;

    state_t             state;
    logic [7:0]         shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   fails;
    logic [CNT_W-1:0]   fails_inc;
    logic [TIMER_W-1:0] timer;
    logic               unlock;
    logic               alarm;

    sync_edge_det u_sync_edge_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .clear     (bus.clear),
        .din_s     (din_s),
        .clear_s   (clear_s),
        .stb       (stb)
    );

    always_comb begin
        fails_inc = fails;
        if (fails < MAX_T) fails_inc = fails + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            shreg   <= '0;
            bit_cnt <= '0;
            fails   <= '0;
            timer   <= '0;
            unlock  <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (clear_s) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (stb) begin
                        shreg <= {shreg[6:0], din_s};
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt <= '0;
                            state   <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    // Every attempt starts from an empty shift register.
                    shreg <= '0;
                    if (shreg == CODE) begin
                        state  <= OPEN;
                        fails  <= '0;
                        timer  <= UNLOCK_T;
                        unlock <= 1'b1;
                    end else begin
                        fails <= fails_inc;
                        if (fails_inc >= MAX_T) begin
                            state <= LOCKOUT;
                            timer <= LOCK_T;
                            alarm <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                OPEN: begin
                    if (timer == '0) begin
                        state  <= COLLECT;
                        unlock <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: begin
                    if (timer == '0) begin
                        state <= COLLECT;
                        alarm <= 1'b0;
                        fails <= '0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.unlock  = unlock;
    assign bus.alarm   = alarm;
    assign bus.bit_cnt = bit_cnt;
    assign bus.fails   = fails;

endmodule
